adquisicion_temp: RTL and testbench
===================================

Name: adquisicion_temp

Overview:
- Upstream stage of monitoreo_top: produces its signed 11-bit temperature input in tenths of °C.
- Periodically reads an external digital temperature sensor over a 3-wire SPI-style serial link (mode 0, MSB first).
- Validates, saturates and 4-tap moving-averages each sample.
- Outputs a held value plus a one-cycle valid strobe.

Parameters:
- DIV_SCLK, 4: clk cycles per spi_sclk half-period (>=2).
- PERIODO_MUESTRA, 1000: clk cycles between conversion starts. Constraint: >= 2*DIV_SCLK*18.
- TEMP_INICIAL, 220: reset value of temp_salida (22.0 °C, inside the normal band 180..259).

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- habilitar  in  1  allow new conversions; a frame in progress always completes
- spi_miso  in  1  sensor serial data
- spi_sclk  out  1  serial clock, idle low
- spi_cs_n  out  1  sensor chip select, active low
- temp_salida  out  11  signed filtered temperature, tenths of °C; connects to temp_entrada of monitoreo_top
- temp_valida  out  1  one-cycle pulse when temp_salida updates
- error_sensor  out  1  last frame had its fault flag set; sticky until the next good frame

Behaviour:
- Reset (async assert, sync release) gives these values:
  - spi_cs_n=1, spi_sclk=0.
  - temp_salida=TEMP_INICIAL, temp_valida=0, error_sensor=0.
  - FSM=REPOSO, tick counter=0, filter marked empty.
- Tick counter:
  - Free-running 0..PERIODO_MUESTRA-1.
  - "tick" is asserted at the wrap to 0.
  - A tick is used only if the FSM is in REPOSO and habilitar=1; otherwise it is dropped. Ticks are not queued.
- FSM states and transitions:
  - REPOSO: spi_cs_n=1, sclk=0. On a usable tick go to SELECCION.
  - SELECCION: spi_cs_n=0 for DIV_SCLK cycles (setup time), then go to TRANSFER.
  - TRANSFER: generate 16 sclk periods, each DIV_SCLK high and DIV_SCLK low, starting with the high phase.
    - Sample spi_miso on the clk cycle where sclk rises.
    - Shift into a 16-bit register, MSB first.
    - After the 16th low phase, go to FIN.
  - FIN: spi_cs_n=1 for exactly 1 cycle; the frame is decoded in this cycle. Then go to REPOSO.
- Frame format:
  - [15:4] raw signed 12-bit temperature, tenths of °C.
  - [3:1] ignored.
  - [0] fault flag, 1 = fault.
- Fault frame (bit0=1):
  - Sample discarded; filter unchanged.
  - temp_salida held; no temp_valida pulse.
  - error_sensor=1 from the first REPOSO cycle.
- Good frame (bit0=0):
  - Saturation: raw clamped to [-1024, 1023] before filtering.
  - Filter is empty: all 4 taps are loaded with the sample, and the filter is marked full.
  - Filter is full: shift the taps (oldest drops).
  - Sum of 4 taps is 13-bit signed. Output = arithmetic shift right by 2 (floor toward -inf); it always fits in 11 bits.
  - temp_salida is registered. temp_valida=1 for exactly the first REPOSO cycle after FIN, so latency from spi_cs_n rising to the strobe is 1 cycle.
  - error_sensor clears in the same cycle.
- habilitar falling mid-frame: the frame completes and is processed normally; no new frame starts.
- Reset mid-transfer: spi_cs_n returns to 1 immediately (asynchronously) and all state returns to reset values. The partial frame is lost and the filter is emptied.
- temp_salida changes only on a temp_valida cycle or on reset.

Decomposition:
- Shared package monitoreo_pkg contains:
  - typedef temp_t (logic signed [10:0]).
  - Constants TEMP_MIN=-1024, TEMP_MAX=1023, TEMP_INICIAL=220.
  - Thresholds 180 and 259, shared with monitoreo_top and the formal bind.
  - enum estado_adq_t {REPOSO, SELECCION, TRANSFER, FIN}.
- Sub-module filtro_promedio:
  - Ports: clk, arst_n, cargar, muestra (temp_t); outputs promedio (temp_t), valido.
  - Owns the 4 taps, the empty/full flag, the sum and the shift.
- The top holds the FSM, the sclk divider, the bit counter and the saturation logic.

Test Plan:
- Reset, then habilitar=1, one good frame raw=250 -> spi_cs_n low 16 sclk periods; temp_salida=250 and temp_valida 1 cycle after spi_cs_n rises; before that temp_salida=220.
- Good frames 250,250,250,170 after fill -> outputs 250,250,250,230 (floor(920/4)).
- Raw 1500 then raw -2000, each on an empty filter (reset between them) -> temp_salida 1023, then -1024.
- Negative floor: samples -1 (fills all taps), then -2,-2,-2 -> last output floor(-7/4) = -2.
- Fault frame (bit0=1) after a 250 output -> no temp_valida, temp_salida stays 250, error_sensor=1; next good frame 250 -> error_sensor=0, temp_valida=1.
- arst_n low during the 8th sclk bit -> spi_cs_n=1 and spi_sclk=0 in the same cycle, temp_salida=220; the next frame raw=300 after release gives 300 (filter refilled, not averaged with old taps). Also check habilitar=0 -> no spi_cs_n activity across 3 tick periods.

Source files
------------

// File: rtl/monitoreo_pkg.sv
// Types, constants and helpers shared by the temperature acquisition stage,
// monitoreo_top and the formal bind.
package monitoreo_pkg;

  // Temperature in tenths of a degree Celsius, signed.
  typedef logic signed [10:0] temp_t;

  localparam int TEMP_MIN     = -1024;
  localparam int TEMP_MAX     = 1023;
  localparam int TEMP_INICIAL = 220;

  // Normal operating band, shared with the monitor and the formal bind.
  localparam int UMBRAL_BAJO  = 180;
  localparam int UMBRAL_ALTO  = 259;

  typedef enum logic [1:0] {
    REPOSO,
    SELECCION,
    TRANSFER,
    FIN
  } estado_adq_t;

  // Clamp a raw signed 12-bit sensor reading into the 11-bit temperature range.
  function automatic temp_t saturar(input logic signed [11:0] crudo);
    if (crudo < TEMP_MIN) begin
      return temp_t'(TEMP_MIN);
    end else if (crudo > TEMP_MAX) begin
      return temp_t'(TEMP_MAX);
    end else begin
      return crudo[10:0];
    end
  endfunction

endpackage

// File: rtl/filtro_promedio.sv
// Four-tap moving average. The first sample after reset fills every tap so
// the output starts at the real temperature instead of ramping from zero.
module filtro_promedio
  import monitoreo_pkg::*;
#(
  parameter temp_t VALOR_INICIAL = temp_t'(TEMP_INICIAL)
) (
  input  logic  clk,
  input  logic  arst_n,
  input  logic  cargar,
  input  temp_t muestra,
  output temp_t promedio,
  output logic  valido
);

  temp_t             tap_reg  [4];
  temp_t             tap_next [4];
  logic              lleno_reg;
  logic signed [12:0] suma;
  temp_t             promedio_reg;
  logic              valido_reg;

  // Tap 0 always takes the new sample; the others shift when full or are
  // preloaded with the same sample while the filter is still empty.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tap
      if (gi == 0) begin : g_primero
        assign tap_next[gi] = muestra;
      end else begin : g_resto
        assign tap_next[gi] = lleno_reg ? tap_reg[gi-1] : muestra;
      end
    end
  endgenerate

  // Sum of the taps as they will be after this load; 13 bits never overflow.
  always_comb begin
    suma = {{2{tap_next[0][10]}}, tap_next[0]}
         + {{2{tap_next[1][10]}}, tap_next[1]}
         + {{2{tap_next[2][10]}}, tap_next[2]}
         + {{2{tap_next[3][10]}}, tap_next[3]};
  end

  // Tap storage and fill flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < 4; i++) begin
        tap_reg[i] <= '0;
      end
      lleno_reg <= 1'b0;
    end else if (cargar) begin
      for (int i = 0; i < 4; i++) begin
        tap_reg[i] <= tap_next[i];
      end
      lleno_reg <= 1'b1;
    end
  end

  // Registered average (dropping two LSBs floors toward -inf) and strobe.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      promedio_reg <= VALOR_INICIAL;
      valido_reg   <= 1'b0;
    end else begin
      valido_reg <= cargar;
      if (cargar) begin
        promedio_reg <= suma[12:2];
      end
    end
  end

  assign promedio = promedio_reg;
  assign valido   = valido_reg;

endmodule

// File: rtl/adquisicion_temp.sv
// Periodic SPI (mode 0, MSB first) reader for a digital temperature sensor.
// Each 16-bit frame is validated, saturated and fed to a 4-tap average.
module adquisicion_temp #(
  parameter int DIV_SCLK        = 4,
  parameter int PERIODO_MUESTRA = 1000,
  parameter int TEMP_INICIAL    = monitoreo_pkg::TEMP_INICIAL
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 habilitar,
  input  logic                 spi_miso,
  output logic                 spi_sclk,
  output logic                 spi_cs_n,
  output monitoreo_pkg::temp_t temp_salida,
  output logic                 temp_valida,
  output logic                 error_sensor
);

  import monitoreo_pkg::*;

  localparam int CNT_W = (PERIODO_MUESTRA > 1) ? $clog2(PERIODO_MUESTRA) : 1;
  localparam int DIV_W = $clog2(DIV_SCLK);

  logic [1:0]       rst_sync_reg;
  logic             rst_int_n;

  logic [CNT_W-1:0] cnt_reg;
  logic             tick;

  estado_adq_t      estado_reg, estado_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic             div_fin;
  logic [3:0]       bit_reg, bit_next;
  logic             sclk_reg, sclk_next;
  logic             cs_n_reg, cs_n_next;
  logic [15:0]      trama_reg, trama_next;
  logic             error_reg, error_next;
  logic             cargar;
  temp_t            muestra;

  // Reset asserts immediately and releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_reg[1];

  // Free-running sample period counter; tick marks the wrap to zero.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick    = (cnt_reg == CNT_W'(PERIODO_MUESTRA - 1));
  assign div_fin = (div_reg == DIV_W'(DIV_SCLK - 1));

  // Frame sequencer, clock divider, bit counter and shift register.
  always_comb begin
    estado_next = estado_reg;
    div_next    = div_reg;
    bit_next    = bit_reg;
    sclk_next   = sclk_reg;
    cs_n_next   = cs_n_reg;
    trama_next  = trama_reg;
    error_next  = error_reg;
    cargar      = 1'b0;

    unique case (estado_reg)
      REPOSO: begin
        cs_n_next = 1'b1;
        sclk_next = 1'b0;
        if (tick && habilitar) begin
          estado_next = SELECCION;
          cs_n_next   = 1'b0;
          div_next    = '0;
        end
      end

      SELECCION: begin
        if (div_fin) begin
          estado_next = TRANSFER;
          div_next    = '0;
          bit_next    = '0;
          sclk_next   = 1'b1;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end

      TRANSFER: begin
        // First cycle of each high phase is the rising edge seen by the sensor.
        if (sclk_reg && (div_reg == '0)) begin
          trama_next = {trama_reg[14:0], spi_miso};
        end
        if (div_fin) begin
          div_next = '0;
          if (sclk_reg) begin
            sclk_next = 1'b0;
          end else if (bit_reg == 4'd15) begin
            estado_next = FIN;
            cs_n_next   = 1'b1;
          end else begin
            bit_next  = bit_reg + 1'b1;
            sclk_next = 1'b1;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end

      FIN: begin
        estado_next = REPOSO;
        cargar      = ~trama_reg[0];
        error_next  = trama_reg[0];
      end

      default: begin
        estado_next = REPOSO;
      end
    endcase
  end

  // Sequencer state and registered SPI outputs.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      estado_reg <= REPOSO;
      div_reg    <= '0;
      bit_reg    <= '0;
      sclk_reg   <= 1'b0;
      cs_n_reg   <= 1'b1;
      trama_reg  <= '0;
      error_reg  <= 1'b0;
    end else begin
      estado_reg <= estado_next;
      div_reg    <= div_next;
      bit_reg    <= bit_next;
      sclk_reg   <= sclk_next;
      cs_n_reg   <= cs_n_next;
      trama_reg  <= trama_next;
      error_reg  <= error_next;
    end
  end

  assign muestra = saturar(trama_reg[15:4]);

  filtro_promedio #(
    .VALOR_INICIAL (temp_t'(TEMP_INICIAL))
  ) u_filtro (
    .clk      (clk),
    .arst_n   (rst_int_n),
    .cargar   (cargar),
    .muestra  (muestra),
    .promedio (temp_salida),
    .valido   (temp_valida)
  );

  assign spi_sclk     = sclk_reg;
  assign spi_cs_n     = cs_n_reg;
  assign error_sensor = error_reg;

endmodule

// File: tb/tb_adquisicion_temp.sv
// Bench for adquisicion_temp: a behavioural sensor drives spi_miso and a
// queue-based averaging model predicts every output.
module tb_adquisicion_temp;

  localparam int DIV  = 4;
  localparam int PER  = 1000;
  localparam int TINI = 220;

  logic               clk = 1'b0;
  logic               arst_n;
  logic               habilitar;
  logic               spi_miso;
  logic               spi_sclk;
  logic               spi_cs_n;
  logic signed [10:0] temp_salida;
  logic               temp_valida;
  logic               error_sensor;

  int n_comparados = 0;
  int n_errores    = 0;

  // Reference model state
  int taps[$];
  int m_salida;
  bit m_err;

  adquisicion_temp #(
    .DIV_SCLK        (DIV),
    .PERIODO_MUESTRA (PER),
    .TEMP_INICIAL    (TINI)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .habilitar    (habilitar),
    .spi_miso     (spi_miso),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .temp_salida  (temp_salida),
    .temp_valida  (temp_valida),
    .error_sensor (error_sensor)
  );

  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input int obs, input int esp);
    n_comparados++;
    if (obs != esp) begin
      n_errores++;
      $display("FAIL %s: observado=%0d esperado=%0d", tag, obs, esp);
    end
  endtask

  task automatic modelo_reset();
    taps.delete();
    m_salida = TINI;
    m_err    = 1'b0;
  endtask

  function automatic int piso4(input int s);
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  // Apply one received frame to the model; reports whether a strobe is due.
  task automatic modelo_trama(input logic [15:0] f, output bit valida);
    logic signed [11:0] crudo;
    int v;
    int suma;
    crudo = f[15:4];
    if (f[0]) begin
      m_err  = 1'b1;
      valida = 1'b0;
    end else begin
      v = int'(crudo);
      if (v < -1024) v = -1024;
      if (v > 1023)  v = 1023;
      if (taps.size() == 0) begin
        for (int i = 0; i < 4; i++) taps.push_back(v);
      end else begin
        taps.push_front(v);
        void'(taps.pop_back());
      end
      suma = 0;
      foreach (taps[i]) suma += taps[i];
      m_salida = piso4(suma);
      m_err    = 1'b0;
      valida   = 1'b1;
    end
  endtask

  function automatic logic [15:0] mk(input int t, input logic [3:0] bajos);
    logic [11:0] r;
    r = t[11:0];
    return {r, bajos};
  endfunction

  // Act as the sensor for one frame and check the DUT around it.
  task automatic trama(input logic [15:0] f, input bit bajar_hab);
    int n;
    int altos;
    int periodos;
    bit v;
    n = 0;
    while (spi_cs_n !== 1'b0 && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    if (spi_cs_n !== 1'b0) begin
      comprobar("cs_baja_timeout", 1, 0);
      return;
    end
    comprobar("temp_antes_trama", temp_salida, m_salida);
    altos    = 0;
    periodos = 0;
    spi_miso = f[15];
    for (int i = 0; i < 16; i++) begin
      n = 0;
      while (spi_sclk !== 1'b1 && n < 4 * DIV) begin
        @(negedge clk);
        n++;
      end
      if (spi_sclk !== 1'b1) begin
        comprobar("sclk_alto_timeout", 0, 1);
        return;
      end
      if (spi_cs_n === 1'b0) periodos++;
      n = 0;
      while (spi_sclk === 1'b1 && n < 4 * DIV) begin
        altos++;
        @(negedge clk);
        n++;
      end
      if (spi_sclk !== 1'b0) begin
        comprobar("sclk_bajo_timeout", 1, 0);
        return;
      end
      if (bajar_hab && i == 7) habilitar = 1'b0;
      if (i < 15) spi_miso = f[14-i];
    end
    comprobar("periodos_sclk", periodos, 16);
    comprobar("ciclos_sclk_alto", altos, 16 * DIV);
    n = 0;
    while (spi_cs_n !== 1'b1 && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    comprobar("cs_sube", spi_cs_n, 1);
    comprobar("valida_en_fin", temp_valida, 0);
    comprobar("temp_en_fin", temp_salida, m_salida);
    modelo_trama(f, v);
    @(negedge clk);
    comprobar("valida", temp_valida, int'(v));
    comprobar("temp_salida", temp_salida, m_salida);
    comprobar("error_sensor", error_sensor, int'(m_err));
    $display("trama %h -> temp_salida=%0d valida=%0d error=%0d (modelo %0d/%0d/%0d)",
             f, temp_salida, temp_valida, error_sensor, m_salida, v, m_err);
    @(negedge clk);
    comprobar("valida_un_ciclo", temp_valida, 0);
  endtask

  task automatic aplicar_reset();
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    modelo_reset();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int subidas;
    int bajas;
    int n;
    logic prev;
    logic [11:0] r;
    logic [2:0]  ign;
    logic        falla;
    logic [15:0] f;
    int          buenas[4];

    arst_n    = 1'b0;
    habilitar = 1'b0;
    spi_miso  = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    modelo_reset();
    repeat (3) @(negedge clk);

    comprobar("reset_cs_n", spi_cs_n, 1);
    comprobar("reset_sclk", spi_sclk, 0);
    comprobar("reset_temp", temp_salida, TINI);
    comprobar("reset_valida", temp_valida, 0);
    comprobar("reset_error", error_sensor, 0);

    habilitar = 1'b1;
    trama(mk(250, 4'h0), 1'b0);

    buenas = '{250, 250, 250, 170};
    foreach (buenas[i]) trama(mk(buenas[i], 4'h0), 1'b0);
    comprobar("promedio_230", temp_salida, 230);

    trama(mk(250, 4'h1), 1'b0);
    comprobar("falla_retiene", temp_salida, 230);
    trama(mk(250, 4'h0), 1'b0);

    aplicar_reset();
    trama(mk(-1, 4'h0), 1'b0);
    for (int i = 0; i < 3; i++) trama(mk(-2, 4'h0), 1'b0);
    comprobar("piso_negativo", temp_salida, -2);

    aplicar_reset();
    trama(mk(1500, 4'h0), 1'b0);
    comprobar("saturacion_alta", temp_salida, 1023);
    aplicar_reset();
    trama(mk(-2000, 4'h0), 1'b0);
    comprobar("saturacion_baja", temp_salida, -1024);

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) == 0) r = 12'(180 + $urandom_range(0, 80));
      else                           r = 12'($urandom_range(0, 4095));
      ign   = 3'($urandom_range(0, 7));
      falla = ($urandom_range(0, 4) == 0);
      f     = {r, ign, falla};
      trama(f, 1'b0);
    end

    // Reset in the middle of the 8th sclk high phase
    n = 0;
    while (spi_cs_n !== 1'b0 && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    spi_miso = 1'b1;
    subidas  = 0;
    prev     = spi_sclk;
    n        = 0;
    while (subidas < 8 && n < 400) begin
      @(negedge clk);
      n++;
      if (spi_sclk === 1'b1 && prev === 1'b0) subidas++;
      prev = spi_sclk;
    end
    comprobar("subidas_antes_reset", subidas, 8);
    arst_n = 1'b0;
    #1;
    comprobar("reset_mitad_cs_n", spi_cs_n, 1);
    comprobar("reset_mitad_sclk", spi_sclk, 0);
    comprobar("reset_mitad_temp", temp_salida, TINI);
    comprobar("reset_mitad_valida", temp_valida, 0);
    $display("reset a mitad de trama -> cs_n=%0d sclk=%0d temp_salida=%0d",
             spi_cs_n, spi_sclk, temp_salida);
    @(negedge clk);
    arst_n = 1'b1;
    modelo_reset();
    trama(mk(300, 4'h0), 1'b0);
    comprobar("relleno_300", temp_salida, 300);

    // habilitar falls mid-frame: the frame completes, nothing new starts
    trama(mk(200, 4'h0), 1'b1);
    bajas = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      @(negedge clk);
      if (spi_cs_n !== 1'b1) bajas++;
    end
    comprobar("sin_actividad_deshabilitado", bajas, 0);
    $display("deshabilitado %0d ciclos -> ciclos con cs_n bajo=%0d", 3 * PER, bajas);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comparados, n_errores);
    $finish;
  end

endmodule
